pipe_run_ctrl: RTL and testbench
================================

Name: pipe_run_ctrl

Overview:
Parametrised successor to the 16-bit pipeline's hazard logic. It merges run control (start/stop sequencing with pipeline drain), load-use and variable-latency data-memory stall detection, control-hazard flushing, and EX-stage forwarding select into one block. It also keeps saturating cycle and stall counters. It sits beside the five-stage datapath and drives every pipeline-register stall/flush plus the forwarding muxes.

Parameters:
REG_WIDTH, 4, register-address width
DRAIN_CYCLES, 4, cycles the pipeline runs after a stop request before halting (1..15)
CNT_WIDTH, 16, width of performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin execution from IDLE or HALT
stop_req  in  1  stop instruction decoded in ID
stop  out  1  registered; high while halted
rsD, rtD  in  REG_WIDTH  ID source registers
rs_usedD, rt_usedD  in  1  ID instruction reads rsD/rtD
jumpD  in  1  jump decoded in ID
rsE, rtE  in  REG_WIDTH  EX source registers
WriteRegE  in  REG_WIDTH  EX destination
MemReadE  in  1  EX instruction is a load
WriteRegM, WriteRegW  in  REG_WIDTH  MEM/WB destinations
RegWriteM, RegWriteW  in  1  MEM/WB write enables
branch_takenM  in  1  branch resolved taken in MEM
dm_req  in  1  MEM stage accessing data memory
dm_ready  in  1  data memory completes access this cycle
pcstall, IF_IDstall, ID_EXstall, EX_MEMstall, MEM_WBstall  out  1  hold the corresponding register
flushIF_ID, flushID_EX, flushEX_MEM  out  1  bubble the corresponding register
alu_src1, alu_src2  out  2  forward select: 00 RF, 01 MEM result, 10 WB result
state  out  2  00 IDLE, 01 RUN, 10 DRAIN, 11 HALT
cycle_cnt, stall_cnt  out  CNT_WIDTH  performance counters

Behaviour:
- Reset (rst=0, async): state=IDLE, stop=0, drain counter=0, both counters=0. Stall/flush outputs follow IDLE decode.
- Stall/flush/forward outputs are combinational from state and inputs. state, stop and the counters are registered.
- IDLE/HALT: all five stalls=1, all flushes=0. start → RUN next edge and clears cycle_cnt/stall_cnt. Other inputs are ignored.
- RUN decode, first match wins:
  1. mem_wait = dm_req & ~dm_ready: all five stalls=1, no flush.
  2. branch_takenM: flushIF_ID=flushID_EX=flushEX_MEM=1, no stall.
  3. load_use = MemReadE & ((rs_usedD & rsD==WriteRegE) | (rt_usedD & rtD==WriteRegE)): pcstall=IF_IDstall=1, flushID_EX=1.
  4. jumpD: flushIF_ID=1.
  5. Otherwise all stalls and flushes are 0.
- RUN with stop_req and no mem_wait/branch_takenM → DRAIN; load drain counter with DRAIN_CYCLES. stop_req under a taken branch is squashed and ignored.
- DRAIN: pcstall=1 and flushIF_ID=1 so no new fetch enters. Otherwise the RUN rules 1–3 apply. Counter decrements only on cycles without mem_wait. At counter 1 with no mem_wait → HALT, stop=1 from the next edge. start and stop_req are ignored in DRAIN.
- HALT: stop stays 1 until start (→RUN, stop=0 next edge) or reset.
- Forwarding, in every state:
  - alu_src1=01 if RegWriteM & WriteRegM==rsE.
  - else 10 if RegWriteW & WriteRegW==rsE.
  - else 00.
  - alu_src2 uses the same rule with rtE. MEM has priority.
- cycle_cnt increments each RUN/DRAIN cycle.
- stall_cnt increments each RUN/DRAIN cycle with mem_wait or load_use.
- Both counters saturate at all-ones and hold their value in IDLE/HALT.
- start in the same cycle as a RUN stop_req: stop_req wins.

Test Plan:
- Reset low mid-RUN → state=00, stop=0, counters 0 immediately. Release, start pulse → state=01 next edge, all stalls 0.
- RUN, MemReadE=1, WriteRegE=3, rsD=3, rs_usedD=1 → pcstall=IF_IDstall=flushID_EX=1 for one cycle; stall_cnt +1.
- dm_req=1, dm_ready=0 for 3 cycles with branch_takenM=1 → all stalls 1 and no flush for 3 cycles. When dm_ready=1 → three flushes asserted.
- RegWriteM=1, WriteRegM=5, RegWriteW=1, WriteRegW=5, rsE=5, rtE=5 → alu_src1=alu_src2=01. Drop RegWriteM → both 10.
- stop_req in RUN, DRAIN_CYCLES=4, one mem_wait cycle inside → HALT after exactly 5 cycles, stop=1, cycle_cnt stops incrementing. Next start → RUN and counters cleared.
- CNT_WIDTH=4, 20 RUN cycles → cycle_cnt=15 and holds.

Source files
------------

// File: rtl/pipe_run_ctrl.sv
// Run control and hazard unit for the five-stage pipeline.
// Provides start/stop sequencing with a bounded drain, stall and flush
// decode, EX-stage forwarding selects, and saturating cycle/stall counters.
module pipe_run_ctrl #(
  parameter int REG_WIDTH    = 4,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop_req,
  output logic                 stop,
  input  logic [REG_WIDTH-1:0] rsD,
  input  logic [REG_WIDTH-1:0] rtD,
  input  logic                 rs_usedD,
  input  logic                 rt_usedD,
  input  logic                 jumpD,
  input  logic [REG_WIDTH-1:0] rsE,
  input  logic [REG_WIDTH-1:0] rtE,
  input  logic [REG_WIDTH-1:0] WriteRegE,
  input  logic                 MemReadE,
  input  logic [REG_WIDTH-1:0] WriteRegM,
  input  logic [REG_WIDTH-1:0] WriteRegW,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic                 branch_takenM,
  input  logic                 dm_req,
  input  logic                 dm_ready,
  output logic                 pcstall,
  output logic                 IF_IDstall,
  output logic                 ID_EXstall,
  output logic                 EX_MEMstall,
  output logic                 MEM_WBstall,
  output logic                 flushIF_ID,
  output logic                 flushID_EX,
  output logic                 flushEX_MEM,
  output logic [1:0]           alu_src1,
  output logic [1:0]           alu_src2,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DRAIN = 2'b10, HALT = 2'b11} state_t;

  state_t     st, st_nxt;
  logic [3:0] drain_cnt, drain_nxt;
  logic       stop_nxt;
  logic       cnt_clr;
  logic       active;
  logic       mem_wait;
  logic       load_use;

  assign state    = st;
  assign active   = (st == RUN) || (st == DRAIN);
  assign mem_wait = dm_req & ~dm_ready;
  assign load_use = MemReadE & ((rs_usedD & (rsD == WriteRegE)) |
                                (rt_usedD & (rtD == WriteRegE)));

  // Stall/flush decode, priority: mem wait, taken branch, load-use, jump
  always_comb begin
    pcstall     = 1'b0;
    IF_IDstall  = 1'b0;
    ID_EXstall  = 1'b0;
    EX_MEMstall = 1'b0;
    MEM_WBstall = 1'b0;
    flushIF_ID  = 1'b0;
    flushID_EX  = 1'b0;
    flushEX_MEM = 1'b0;
    if (!active) begin
      {pcstall, IF_IDstall, ID_EXstall, EX_MEMstall, MEM_WBstall} = 5'b11111;
    end else if (mem_wait) begin
      {pcstall, IF_IDstall, ID_EXstall, EX_MEMstall, MEM_WBstall} = 5'b11111;
    end else begin
      if (branch_takenM) begin
        {flushIF_ID, flushID_EX, flushEX_MEM} = 3'b111;
      end else if (load_use) begin
        pcstall    = 1'b1;
        IF_IDstall = 1'b1;
        flushID_EX = 1'b1;
      end else if (jumpD) begin
        flushIF_ID = 1'b1;
      end
      // While draining, fetch is frozen and IF/ID is fed bubbles, except
      // when a load-use hold must keep the instruction sitting in ID.
      if (st == DRAIN) begin
        pcstall = 1'b1;
        if (branch_takenM || !load_use) flushIF_ID = 1'b1;
      end
    end
  end

  // Forwarding select for EX operands; MEM result beats WB result
  always_comb begin
    alu_src1 = 2'b00;
    alu_src2 = 2'b00;
    if (RegWriteM && (WriteRegM == rsE))      alu_src1 = 2'b01;
    else if (RegWriteW && (WriteRegW == rsE)) alu_src1 = 2'b10;
    if (RegWriteM && (WriteRegM == rtE))      alu_src2 = 2'b01;
    else if (RegWriteW && (WriteRegW == rtE)) alu_src2 = 2'b10;
  end

  // Run-state sequencing and drain countdown
  always_comb begin
    st_nxt    = st;
    drain_nxt = drain_cnt;
    stop_nxt  = stop;
    cnt_clr   = 1'b0;
    case (st)
      IDLE, HALT: begin
        if (start) begin
          st_nxt   = RUN;
          stop_nxt = 1'b0;
          cnt_clr  = 1'b1;
        end
      end
      RUN: begin
        // A stop decoded under a taken branch is on the wrong path
        if (stop_req && !mem_wait && !branch_takenM) begin
          st_nxt    = DRAIN;
          drain_nxt = 4'(DRAIN_CYCLES);
        end
      end
      default: begin
        if (!mem_wait) begin
          if (drain_cnt == 4'd1) begin
            st_nxt    = HALT;
            stop_nxt  = 1'b1;
            drain_nxt = 4'd0;
          end else begin
            drain_nxt = drain_cnt - 4'd1;
          end
        end
      end
    endcase
  end

  // State, stop flag and drain counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      stop      <= 1'b0;
      drain_cnt <= 4'd0;
    end else begin
      st        <= st_nxt;
      stop      <= stop_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  // Saturating performance counters, cleared on each start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
    end else if (active) begin
      if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
      if ((mem_wait || load_use) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Scoreboard bench for pipe_run_ctrl: expectations are queued as stimulus
// is applied and popped when the corresponding output is sampled.
module tb_pipe_run_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop_req;
  logic [3:0] rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW;
  logic       rs_usedD, rt_usedD, jumpD, MemReadE, RegWriteM, RegWriteW;
  logic       branch_takenM, dm_req, dm_ready;

  logic        stop, pcstall, IF_IDstall, ID_EXstall, EX_MEMstall, MEM_WBstall;
  logic        flushIF_ID, flushID_EX, flushEX_MEM;
  logic [1:0]  alu_src1, alu_src2, state;
  logic [15:0] cycle_cnt, stall_cnt;

  logic        s_stop, s_pc, s_ifid, s_idex, s_exmem, s_memwb, s_fif, s_fid, s_fex;
  logic [1:0]  s_src1, s_src2, s_state;
  logic [3:0]  s_cyc, s_stall;

  logic [15:0] exp_q[$];
  logic [15:0] e;
  int          checks = 0;
  int          errors = 0;

  wire [7:0] ctrl = {pcstall, IF_IDstall, ID_EXstall, EX_MEMstall, MEM_WBstall,
                     flushIF_ID, flushID_EX, flushEX_MEM};

  always #5 clk = ~clk;

  pipe_run_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop_req(stop_req), .stop(stop),
    .rsD(rsD), .rtD(rtD), .rs_usedD(rs_usedD), .rt_usedD(rt_usedD), .jumpD(jumpD),
    .rsE(rsE), .rtE(rtE), .WriteRegE(WriteRegE), .MemReadE(MemReadE),
    .WriteRegM(WriteRegM), .WriteRegW(WriteRegW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .branch_takenM(branch_takenM), .dm_req(dm_req), .dm_ready(dm_ready),
    .pcstall(pcstall), .IF_IDstall(IF_IDstall), .ID_EXstall(ID_EXstall),
    .EX_MEMstall(EX_MEMstall), .MEM_WBstall(MEM_WBstall),
    .flushIF_ID(flushIF_ID), .flushID_EX(flushID_EX), .flushEX_MEM(flushEX_MEM),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .state(state),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
  );

  // Narrow-counter instance sharing all stimulus, used for saturation
  pipe_run_ctrl #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .stop_req(stop_req), .stop(s_stop),
    .rsD(rsD), .rtD(rtD), .rs_usedD(rs_usedD), .rt_usedD(rt_usedD), .jumpD(jumpD),
    .rsE(rsE), .rtE(rtE), .WriteRegE(WriteRegE), .MemReadE(MemReadE),
    .WriteRegM(WriteRegM), .WriteRegW(WriteRegW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .branch_takenM(branch_takenM), .dm_req(dm_req), .dm_ready(dm_ready),
    .pcstall(s_pc), .IF_IDstall(s_ifid), .ID_EXstall(s_idex),
    .EX_MEMstall(s_exmem), .MEM_WBstall(s_memwb),
    .flushIF_ID(s_fif), .flushID_EX(s_fid), .flushEX_MEM(s_fex),
    .alu_src1(s_src1), .alu_src2(s_src2), .state(s_state),
    .cycle_cnt(s_cyc), .stall_cnt(s_stall)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    start = 0; stop_req = 0; rsD = 0; rtD = 0; rs_usedD = 0; rt_usedD = 0; jumpD = 0;
    rsE = 0; rtE = 0; WriteRegE = 0; MemReadE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteM = 0; RegWriteW = 0; branch_takenM = 0; dm_req = 0; dm_ready = 0;
  endtask

  task automatic test_reset();
    rst = 0; clr_in();
    repeat (2) step();
    rst = 1; step();
    start = 1; step(); start = 0;
    repeat (3) step();
    exp_q.push_back(16'h0001);      // state RUN before reset
    e = exp_q.pop_front(); checks++;
    if ({14'd0, state} !== e) begin errors++; $display("FAIL pre_reset_state act=%h exp=%h", state, e); end
    // Asynchronous reset mid-cycle
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h00F8);
    #2 rst = 0; #1;
    e = exp_q.pop_front(); checks++;
    if ({14'd0, state} !== e) begin errors++; $display("FAIL reset_state act=%h exp=%h", state, e); end
    e = exp_q.pop_front(); checks++;
    if ({15'd0, stop} !== e) begin errors++; $display("FAIL reset_stop act=%h exp=%h", stop, e); end
    e = exp_q.pop_front(); checks++;
    if (cycle_cnt !== e) begin errors++; $display("FAIL reset_cycle_cnt act=%h exp=%h", cycle_cnt, e); end
    e = exp_q.pop_front(); checks++;
    if (stall_cnt !== e) begin errors++; $display("FAIL reset_stall_cnt act=%h exp=%h", stall_cnt, e); end
    e = exp_q.pop_front(); checks++;
    if ({8'd0, ctrl} !== e) begin errors++; $display("FAIL reset_ctrl act=%h exp=%h", ctrl, e); end
    step(); rst = 1; step();
    exp_q.push_back(16'h0000);
    e = exp_q.pop_front(); checks++;
    if ({14'd0, state} !== e) begin errors++; $display("FAIL idle_hold act=%h exp=%h", state, e); end
    start = 1; step(); start = 0;
    exp_q.push_back(16'h0001); exp_q.push_back(16'h0000);
    e = exp_q.pop_front(); checks++;
    if ({14'd0, state} !== e) begin errors++; $display("FAIL start_state act=%h exp=%h", state, e); end
    e = exp_q.pop_front(); checks++;
    if ({8'd0, ctrl} !== e) begin errors++; $display("FAIL run_ctrl act=%h exp=%h", ctrl, e); end
  endtask

  task automatic test_load_use();
    logic [15:0] s0;
    s0 = stall_cnt;
    // rs hazard
    MemReadE = 1; WriteRegE = 3; rsD = 3; rs_usedD = 1;
    exp_q.push_back(16'h00C2); #1;
    e = exp_q.pop_front(); checks++;
    if ({8'd0, ctrl} !== e) begin errors++; $display("FAIL load_use_rs act=%h exp=%h", ctrl, e); end
    step(); clr_in();
    exp_q.push_back(s0 + 16'd1); exp_q.push_back(16'h0000); #1;
    e = exp_q.pop_front(); checks++;
    if (stall_cnt !== e) begin errors++; $display("FAIL load_use_cnt act=%h exp=%h", stall_cnt, e); end
    e = exp_q.pop_front(); checks++;
    if ({8'd0, ctrl} !== e) begin errors++; $display("FAIL load_use_clear act=%h exp=%h", ctrl, e); end
    // rt hazard
    MemReadE = 1; WriteRegE = 7; rtD = 7; rt_usedD = 1; rsD = 2; rs_usedD = 1;
    exp_q.push_back(16'h00C2); #1;
    e = exp_q.pop_front(); checks++;
    if ({8'd0, ctrl} !== e) begin errors++; $display("FAIL load_use_rt act=%h exp=%h", ctrl, e); end
    step(); clr_in();
    // Matching register that is not read: no hazard
    MemReadE = 1; WriteRegE = 3; rsD = 3; rs_usedD = 0;
    exp_q.push_back(16'h0000); #1;
    e = exp_q.pop_front(); checks++;
    if ({8'd0, ctrl} !== e) begin errors++; $display("FAIL load_use_unused act=%h exp=%h", ctrl, e); end
    step(); clr_in();
    jumpD = 1;
    exp_q.push_back(16'h0004); #1;
    e = exp_q.pop_front(); checks++;
    if ({8'd0, ctrl} !== e) begin errors++; $display("FAIL jump act=%h exp=%h", ctrl, e); end
    step(); clr_in();
  endtask

  task automatic test_mem_wait();
    logic [15:0] s0;
    s0 = stall_cnt;
    for (int i = 0; i < 3; i++) begin
      dm_req = 1; dm_ready = 0; branch_takenM = 1; stop_req = 1;
      exp_q.push_back(16'h00F8); #1;
      e = exp_q.pop_front(); checks++;
      if ({8'd0, ctrl} !== e) begin errors++; $display("FAIL mem_wait_%0d act=%h exp=%h", i, ctrl, e); end
      step();
    end
    dm_ready = 1;
    exp_q.push_back(16'h0007); #1;
    e = exp_q.pop_front(); checks++;
    if ({8'd0, ctrl} !== e) begin errors++; $display("FAIL branch_flush act=%h exp=%h", ctrl, e); end
    step(); clr_in();
    exp_q.push_back(16'h0001); exp_q.push_back(s0 + 16'd3);
    e = exp_q.pop_front(); checks++;
    if ({14'd0, state} !== e) begin errors++; $display("FAIL squashed_stop act=%h exp=%h", state, e); end
    e = exp_q.pop_front(); checks++;
    if (stall_cnt !== e) begin errors++; $display("FAIL mem_wait_cnt act=%h exp=%h", stall_cnt, e); end
  endtask

  task automatic test_forward();
    logic [3:0] rw_m[4]  = '{1, 0, 1, 1};
    logic [3:0] rw_w[4]  = '{1, 1, 1, 0};
    logic [3:0] wm[4]    = '{5, 5, 2, 2};
    logic [3:0] ww[4]    = '{5, 5, 6, 6};
    logic [3:0] rs[4]    = '{5, 5, 2, 2};
    logic [3:0] rt[4]    = '{5, 5, 6, 6};
    logic [3:0] expv[4]  = '{4'b0101, 4'b1010, 4'b0110, 4'b0100};
    for (int i = 0; i < 4; i++) begin
      RegWriteM = rw_m[i][0]; RegWriteW = rw_w[i][0];
      WriteRegM = wm[i]; WriteRegW = ww[i]; rsE = rs[i]; rtE = rt[i];
      exp_q.push_back({12'd0, expv[i]}); #1;
      e = exp_q.pop_front(); checks++;
      if ({12'd0, alu_src1, alu_src2} !== e)
        begin errors++; $display("FAIL forward_%0d act=%h exp=%h", i, {alu_src1, alu_src2}, e); end
      step();
    end
    clr_in();
  endtask

  task automatic test_drain();
    logic [15:0] c0, s0;
    c0 = cycle_cnt; s0 = stall_cnt;
    // start alongside stop_req in RUN: stop wins
    stop_req = 1; start = 1;
    step(); clr_in();
    exp_q.push_back(16'h0002); exp_q.push_back(16'h0084); #1;
    e = exp_q.pop_front(); checks++;
    if ({14'd0, state} !== e) begin errors++; $display("FAIL drain_enter act=%h exp=%h", state, e); end
    e = exp_q.pop_front(); checks++;
    if ({8'd0, ctrl} !== e) begin errors++; $display("FAIL drain_ctrl act=%h exp=%h", ctrl, e); end
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin dm_req = 1; dm_ready = 0; end
      if (i == 2) start = 1;
      exp_q.push_back(16'h0002); #1;
      e = exp_q.pop_front(); checks++;
      if ({14'd0, state} !== e) begin errors++; $display("FAIL drain_cycle_%0d act=%h exp=%h", i, state, e); end
      step(); clr_in();
    end
    exp_q.push_back(16'h0003); exp_q.push_back(16'h0001);
    exp_q.push_back(c0 + 16'd6); exp_q.push_back(s0 + 16'd1);
    e = exp_q.pop_front(); checks++;
    if ({14'd0, state} !== e) begin errors++; $display("FAIL halt_state act=%h exp=%h", state, e); end
    e = exp_q.pop_front(); checks++;
    if ({15'd0, stop} !== e) begin errors++; $display("FAIL halt_stop act=%h exp=%h", stop, e); end
    e = exp_q.pop_front(); checks++;
    if (cycle_cnt !== e) begin errors++; $display("FAIL drain_cycle_cnt act=%h exp=%h", cycle_cnt, e); end
    e = exp_q.pop_front(); checks++;
    if (stall_cnt !== e) begin errors++; $display("FAIL drain_stall_cnt act=%h exp=%h", stall_cnt, e); end
    repeat (3) step();
    exp_q.push_back(c0 + 16'd6); exp_q.push_back(16'h00F8); exp_q.push_back(16'h0001);
    e = exp_q.pop_front(); checks++;
    if (cycle_cnt !== e) begin errors++; $display("FAIL halt_cnt_hold act=%h exp=%h", cycle_cnt, e); end
    e = exp_q.pop_front(); checks++;
    if ({8'd0, ctrl} !== e) begin errors++; $display("FAIL halt_ctrl act=%h exp=%h", ctrl, e); end
    e = exp_q.pop_front(); checks++;
    if ({15'd0, stop} !== e) begin errors++; $display("FAIL halt_stop_hold act=%h exp=%h", stop, e); end
    start = 1; step(); start = 0;
    exp_q.push_back(16'h0001); exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    e = exp_q.pop_front(); checks++;
    if ({14'd0, state} !== e) begin errors++; $display("FAIL restart_state act=%h exp=%h", state, e); end
    e = exp_q.pop_front(); checks++;
    if ({15'd0, stop} !== e) begin errors++; $display("FAIL restart_stop act=%h exp=%h", stop, e); end
    e = exp_q.pop_front(); checks++;
    if (cycle_cnt !== e) begin errors++; $display("FAIL restart_cycle_cnt act=%h exp=%h", cycle_cnt, e); end
    e = exp_q.pop_front(); checks++;
    if (stall_cnt !== e) begin errors++; $display("FAIL restart_stall_cnt act=%h exp=%h", stall_cnt, e); end
  endtask

  task automatic test_saturate();
    repeat (20) step();
    exp_q.push_back(16'h000F); exp_q.push_back(16'd20);
    e = exp_q.pop_front(); checks++;
    if ({12'd0, s_cyc} !== e) begin errors++; $display("FAIL sat_cnt act=%h exp=%h", s_cyc, e); end
    e = exp_q.pop_front(); checks++;
    if (cycle_cnt !== e) begin errors++; $display("FAIL wide_cnt act=%h exp=%h", cycle_cnt, e); end
    step();
    exp_q.push_back(16'h000F);
    e = exp_q.pop_front(); checks++;
    if ({12'd0, s_cyc} !== e) begin errors++; $display("FAIL sat_hold act=%h exp=%h", s_cyc, e); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mem_wait();
    test_forward();
    test_drain();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
